// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, the IF/ID register and a one-word hold buffer.
// Talks to a variable-latency instruction memory with at most one request in flight.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        IFWrite,
    input  logic        Branch,
    input  logic        Jump,
    input  logic [31:0] JumpAddr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction_id,
    output logic [31:0] PC_id
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]  state_r;
    logic [31:0] pc_f_r;
    logic [31:0] rsp_pc_r;
    logic        kill_r;
    logic        pend_r;
    logic [31:0] pend_addr_r;
    logic        hold_valid_r;
    logic [31:0] hold_insn_r;
    logic [31:0] hold_pc_r;
    logic [31:0] insn_id_r;
    logic [31:0] pc_id_r;

    logic        redirect_s;
    logic        rsp_ok_s;
    logic        chain_s;
    logic        req_s;
    logic        accept_s;
    logic [31:0] target_s;

    // Request generation and response qualification.
    always_comb begin
        redirect_s = IFWrite & (Branch | Jump);
        rsp_ok_s   = imem_rvalid & ~kill_r;
        target_s   = JumpAddr & ~32'h0000_0003;
        // A follow-on request is only safe when the returning word cannot end up stuck in a full buffer.
        chain_s    = imem_rvalid & ~redirect_s & (IFWrite | kill_r);
        case (state_r)
            S_REQ:   req_s = 1'b1;
            S_WAIT:  req_s = chain_s;
            S_HOLD:  req_s = 1'b0;
            default: req_s = 1'b0;
        endcase
        accept_s = req_s & imem_ready;
    end

    assign imem_req       = req_s & rst_n;
    assign imem_addr      = pc_f_r;
    assign Instruction_id = insn_id_r;
    assign PC_id          = pc_id_r;

    // Fetch FSM, fetch PC and wrong-path kill tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_REQ;
            pc_f_r      <= RESET_PC;
            rsp_pc_r    <= RESET_PC;
            kill_r      <= 1'b0;
            pend_r      <= 1'b0;
            pend_addr_r <= RESET_PC;
        end else begin
            case (state_r)
                S_REQ: begin
                    if (accept_s) begin
                        rsp_pc_r <= pc_f_r;
                        state_r  <= S_WAIT;
                        pend_r   <= 1'b0;
                        if (redirect_s) begin
                            pc_f_r <= target_s;
                            kill_r <= 1'b1;
                        end else if (pend_r) begin
                            pc_f_r <= pend_addr_r;
                        end else begin
                            pc_f_r <= pc_f_r + 32'd4;
                        end
                    end else if (redirect_s) begin
                        // Request must finish at its old address; remember where to go afterwards.
                        pend_r      <= 1'b1;
                        pend_addr_r <= target_s;
                        kill_r      <= 1'b1;
                    end else begin
                        pend_r <= pend_r;
                    end
                end
                S_WAIT: begin
                    if (redirect_s) begin
                        pc_f_r <= target_s;
                        if (imem_rvalid) begin
                            kill_r  <= 1'b0;
                            state_r <= S_REQ;
                        end else begin
                            kill_r <= 1'b1;
                        end
                    end else if (imem_rvalid) begin
                        kill_r <= 1'b0;
                        if (chain_s) begin
                            if (accept_s) begin
                                rsp_pc_r <= pc_f_r;
                                pc_f_r   <= pc_f_r + 32'd4;
                            end else begin
                                state_r <= S_REQ;
                            end
                        end else begin
                            state_r <= S_HOLD;
                        end
                    end else begin
                        kill_r <= kill_r;
                    end
                end
                S_HOLD: begin
                    if (IFWrite) begin
                        state_r <= S_REQ;
                        if (redirect_s) begin
                            pc_f_r <= target_s;
                        end else begin
                            pc_f_r <= pc_f_r;
                        end
                    end else begin
                        state_r <= S_HOLD;
                    end
                end
                default: state_r <= S_REQ;
            endcase
        end
    end

    // IF/ID register and hold buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            insn_id_r    <= NOP_INSN;
            pc_id_r      <= RESET_PC;
            hold_valid_r <= 1'b0;
            hold_insn_r  <= NOP_INSN;
            hold_pc_r    <= RESET_PC;
        end else if (IFWrite) begin
            if (redirect_s) begin
                insn_id_r    <= NOP_INSN;
                hold_valid_r <= 1'b0;
            end else if (hold_valid_r) begin
                insn_id_r    <= hold_insn_r;
                pc_id_r      <= hold_pc_r;
                hold_valid_r <= rsp_ok_s;
                if (rsp_ok_s) begin
                    hold_insn_r <= imem_rdata;
                    hold_pc_r   <= rsp_pc_r;
                end else begin
                    hold_insn_r <= hold_insn_r;
                end
            end else if (rsp_ok_s) begin
                insn_id_r <= imem_rdata;
                pc_id_r   <= rsp_pc_r;
            end else begin
                insn_id_r <= NOP_INSN;
            end
        end else if (rsp_ok_s) begin
            hold_valid_r <= 1'b1;
            hold_insn_r  <= imem_rdata;
            hold_pc_r    <= rsp_pc_r;
        end else begin
            hold_valid_r <= hold_valid_r;
        end
    end

endmodule
